// File: rtl/ddc_pkg.sv
// Shared widths and fixed-point constants for the DDC mixer/decimator and
// the FIR output stages that reuse the same round/saturate block.
package ddc_pkg;

  localparam int unsigned def_mpr = 16;
  localparam int unsigned def_dw  = 16;
  localparam int unsigned def_ow  = 16;
  localparam int unsigned def_rw  = 8;

  localparam int round_k = 2 ** (def_mpr - 2);
  localparam int sat_hi  = 2 ** (def_ow - 1) - 1;
  localparam int sat_lo  = -(2 ** (def_ow - 1));

endpackage

// File: rtl/ddc_round_sat.sv
// Combinational round-half-up and saturate of a full-width signed product
// down to ow bits, dropping mpr-1 fractional bits.
module ddc_round_sat
  import ddc_pkg::*;
#(
  parameter int unsigned mpr = def_mpr,
  parameter int unsigned dw  = def_dw,
  parameter int unsigned ow  = def_ow
) (
  input  logic signed [dw+mpr-1:0] prod,
  output logic signed [ow-1:0]     res
);

  localparam int unsigned pw = dw + mpr;

  // One guard bit so the rounding add can never wrap.
  localparam logic signed [pw:0] rnd = (pw + 1)'(1) << (mpr - 2);
  localparam logic signed [pw:0] hi  = ((pw + 1)'(1) << (ow - 1)) - (pw + 1)'(1);
  localparam logic signed [pw:0] lo  = -((pw + 1)'(1) << (ow - 1));

  logic signed [pw:0] rounded;
  logic signed [pw:0] shifted;

  always_comb begin
    rounded = {prod[pw-1], prod} + rnd;
    shifted = rounded >>> (mpr - 1);
    if (shifted > hi)
      res = hi[ow-1:0];
    else if (shifted < lo)
      res = lo[ow-1:0];
    else
      res = shifted[ow-1:0];
  end

endmodule

// File: rtl/ddc_mixer_dec.sv
// DDC mixer (ADC x NCO sine, rounded/saturated) followed by an
// integrate-and-dump decimator of ratio R.
module ddc_mixer_dec
  import ddc_pkg::*;
#(
  parameter int unsigned mpr = def_mpr,
  parameter int unsigned dw  = def_dw,
  parameter int unsigned ow  = def_ow,
  parameter int unsigned rw  = def_rw
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic [dw-1:0]     adc_i,
  input  logic [mpr-1:0]    nco_sin_i,
  input  logic              nco_valid_i,
  input  logic [rw-1:0]     dec_r_i,
  output logic [ow-1:0]     mix_o,
  output logic              mix_valid_o,
  output logic [ow+rw-1:0]  acc_o,
  output logic              acc_valid_o
);

  logic signed [dw-1:0]      a_q;
  logic signed [mpr-1:0]     s_q;
  logic signed [dw+mpr-1:0]  p_q;
  logic signed [ow-1:0]      q_c;
  logic                      v1;
  logic                      v2;

  logic [rw-1:0]             cnt;
  logic [rw-1:0]             r_q;
  logic [rw-1:0]             r_live;
  logic [rw-1:0]             r_eff;
  logic signed [ow+rw-1:0]   acc;
  logic signed [ow+rw-1:0]   acc_next;

  ddc_round_sat #(
    .mpr (mpr),
    .dw  (dw),
    .ow  (ow)
  ) u_round_sat (
    .prod (p_q),
    .res  (q_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      s_q         <= '0;
      v1          <= 1'b0;
      p_q         <= '0;
      v2          <= 1'b0;
      mix_o       <= '0;
      mix_valid_o <= 1'b0;
    end else if (clken) begin
      a_q         <= adc_i;
      s_q         <= nco_sin_i;
      v1          <= nco_valid_i;
      p_q         <= (dw + mpr)'(a_q) * (dw + mpr)'(s_q);
      v2          <= v1;
      mix_o       <= q_c;
      mix_valid_o <= v2;
    end
  end

  // The first sample of a frame uses the live ratio; later samples use the
  // value latched alongside it, so mid-frame changes wait for the next frame.
  always_comb begin
    r_live   = (dec_r_i == '0) ? rw'(1) : dec_r_i;
    r_eff    = (cnt == '0) ? r_live : r_q;
    acc_next = acc + {{rw{mix_o[ow-1]}}, mix_o};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      r_q         <= rw'(1);
      acc         <= '0;
      acc_o       <= '0;
      acc_valid_o <= 1'b0;
    end else if (clken) begin
      if (mix_valid_o) begin
        if (cnt == '0)
          r_q <= r_live;
        if (cnt == r_eff - rw'(1)) begin
          acc_o       <= acc_next;
          acc_valid_o <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
        end else begin
          acc         <= acc_next;
          cnt         <= cnt + rw'(1);
          acc_valid_o <= 1'b0;
        end
      end else begin
        acc_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddc_mixer_dec.sv
// Directed bench for ddc_mixer_dec: mixer vector table, decimation frames,
// reset/ratio-change corner cases and a clken/valid stall run.
module tb_ddc_mixer_dec;

  localparam int unsigned mpr = 16;
  localparam int unsigned dw  = 16;
  localparam int unsigned ow  = 16;
  localparam int unsigned rw  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              clken;
  logic [dw-1:0]     adc_i;
  logic [mpr-1:0]    nco_sin_i;
  logic              nco_valid_i;
  logic [rw-1:0]     dec_r_i;
  logic [ow-1:0]     mix_o;
  logic              mix_valid_o;
  logic [ow+rw-1:0]  acc_o;
  logic              acc_valid_o;

  always #5 clk = ~clk;

  ddc_mixer_dec #(
    .mpr (mpr),
    .dw  (dw),
    .ow  (ow),
    .rw  (rw)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clken       (clken),
    .adc_i       (adc_i),
    .nco_sin_i   (nco_sin_i),
    .nco_valid_i (nco_valid_i),
    .dec_r_i     (dec_r_i),
    .mix_o       (mix_o),
    .mix_valid_o (mix_valid_o),
    .acc_o       (acc_o),
    .acc_valid_o (acc_valid_o)
  );

  typedef struct {
    int adc;
    int sin;
    int mix;
  } vec_t;

  vec_t vecs[12];
  int   tests = 0;
  int   fails = 0;
  int   exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle with sine fixed at 0.5 full scale, so each accepted sample
  // mixes to exactly adc/2 for even adc. Checks hold behaviour on stalled
  // cycles and pops the expected sum on every enabled acc pulse.
  task automatic drive(input logic ce, input logic vld, input int adc);
    logic [ow-1:0]    pm;
    logic             pmv;
    logic [ow+rw-1:0] pa;
    logic             pav;
    clken       = ce;
    nco_valid_i = vld;
    adc_i       = dw'(adc);
    nco_sin_i   = mpr'(16384);
    pm  = mix_o;
    pmv = mix_valid_o;
    pa  = acc_o;
    pav = acc_valid_o;
    step();
    if (!ce) begin
      check("hold_mix", mix_o, pm);
      check("hold_mix_valid", mix_valid_o, pmv);
      check("hold_acc", acc_o, pa);
      check("hold_acc_valid", acc_valid_o, pav);
    end else if (acc_valid_o) begin
      if (exp_q.size() == 0)
        check("unexpected_pulse", acc_valid_o, 0);
      else
        check("acc_sum", $signed(acc_o), exp_q.pop_front());
    end
  endtask

  task automatic flush();
    repeat (6) drive(1'b1, 1'b0, 0);
    check("missing_pulses", exp_q.size(), 0);
  endtask

  initial begin
    int first;
    int sum;
    int n;
    logic ce;
    logic vld;
    int adc;

    vecs[0]  = '{16384, 16384, 8192};
    vecs[1]  = '{-32768, -32768, 32767};
    vecs[2]  = '{1, 16384, 1};
    vecs[3]  = '{-1, 16384, 0};
    vecs[4]  = '{32767, 32767, 32766};
    vecs[5]  = '{-32768, 32767, -32767};
    vecs[6]  = '{200, 16384, 100};
    vecs[7]  = '{-100, 16384, -50};
    vecs[8]  = '{400, 16384, 200};
    vecs[9]  = '{14, 16384, 7};
    vecs[10] = '{3, 16384, 2};
    vecs[11] = '{-3, 16384, -1};

    // Reset with busy inputs
    reset       = 1'b1;
    clken       = 1'b1;
    adc_i       = dw'(123);
    nco_sin_i   = mpr'(456);
    nco_valid_i = 1'b1;
    dec_r_i     = rw'(1);
    repeat (3) step();
    check("rst_mix", mix_o, 0);
    check("rst_mix_valid", mix_valid_o, 0);
    check("rst_acc", acc_o, 0);
    check("rst_acc_valid", acc_valid_o, 0);
    reset       = 1'b0;
    nco_valid_i = 1'b0;
    repeat (5) step();
    check("idle_mix_valid", mix_valid_o, 0);
    check("idle_acc_valid", acc_valid_o, 0);

    // Mixer vectors, R=1 so every sample also dumps straight to acc_o
    for (int i = 0; i < 12; i++) begin
      adc_i       = dw'(vecs[i].adc);
      nco_sin_i   = mpr'(vecs[i].sin);
      nco_valid_i = 1'b1;
      step();
      nco_valid_i = 1'b0;
      step();
      step();
      check($sformatf("mix_v%0d", i), $signed(mix_o), vecs[i].mix);
      check($sformatf("mix_valid_v%0d", i), mix_valid_o, 1);
      step();
      check($sformatf("acc_valid_v%0d", i), acc_valid_o, 1);
      check($sformatf("acc_v%0d", i), $signed(acc_o), vecs[i].mix);
    end
    repeat (4) step();

    // R=1 continuous stream: latency and steady pulses
    adc_i       = dw'(16384);
    nco_sin_i   = mpr'(16384);
    nco_valid_i = 1'b1;
    first = 0;
    for (int i = 1; i <= 10 && first == 0; i++) begin
      step();
      if (acc_valid_o) first = i;
    end
    check("r1_latency", first, 4);
    for (int i = 0; i < 4; i++) begin
      step();
      check("r1_acc_valid", acc_valid_o, 1);
      check("r1_acc", $signed(acc_o), 8192);
      check("r1_mix", $signed(mix_o), 8192);
    end
    nco_valid_i = 1'b0;
    repeat (5) step();

    // R=4: two frames back to back
    dec_r_i = rw'(4);
    exp_q.push_back(257);
    exp_q.push_back(10);
    drive(1'b1, 1'b1, 200);
    drive(1'b1, 1'b1, -100);
    drive(1'b1, 1'b1, 400);
    drive(1'b1, 1'b1, 14);
    drive(1'b1, 1'b1, 2);
    drive(1'b1, 1'b1, 4);
    drive(1'b1, 1'b1, 6);
    drive(1'b1, 1'b1, 8);
    flush();

    // Reset mid-frame discards the partial sum
    drive(1'b1, 1'b1, 100);
    drive(1'b1, 1'b1, 100);
    drive(1'b1, 1'b0, 0);
    reset = 1'b1;
    drive(1'b1, 1'b0, 0);
    check("rst_mid_acc_valid", acc_valid_o, 0);
    reset = 1'b0;
    exp_q.push_back(100);
    drive(1'b1, 1'b1, 20);
    drive(1'b1, 1'b1, 40);
    drive(1'b1, 1'b1, 60);
    drive(1'b1, 1'b1, 80);
    flush();

    // R 4 -> 2 after the frame's first sample reaches the decimator
    exp_q.push_back(10);
    exp_q.push_back(11);
    exp_q.push_back(15);
    drive(1'b1, 1'b1, 2);
    repeat (3) drive(1'b1, 1'b0, 0);
    dec_r_i = rw'(2);
    drive(1'b1, 1'b1, 4);
    drive(1'b1, 1'b1, 6);
    drive(1'b1, 1'b1, 8);
    drive(1'b1, 1'b1, 10);
    drive(1'b1, 1'b1, 12);
    drive(1'b1, 1'b1, 14);
    drive(1'b1, 1'b1, 16);
    flush();

    // R=0 behaves as R=1
    dec_r_i = '0;
    exp_q.push_back(10);
    exp_q.push_back(-20);
    exp_q.push_back(30);
    drive(1'b1, 1'b1, 20);
    drive(1'b1, 1'b1, -40);
    drive(1'b1, 1'b1, 60);
    flush();

    // R=3 with pseudo-random clken stalls and valid gaps
    dec_r_i = rw'(3);
    sum = 0;
    n   = 0;
    for (int i = 0; i < 120; i++) begin
      ce  = ($urandom_range(0, 3) != 0);
      vld = ($urandom_range(0, 2) != 0);
      adc = 2 * (int'($urandom_range(0, 4000)) - 2000);
      if (ce && vld) begin
        sum += adc / 2;
        n++;
        if (n == 3) begin
          exp_q.push_back(sum);
          sum = 0;
          n   = 0;
        end
      end
      drive(ce, vld, adc);
    end
    flush();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ddc_mixer_dec.md
# ddc_mixer_dec

Digital down-converter mixer and integrate-and-dump decimator, directly downstream of the NCO. Multiplies each ADC sample by the NCO sine output (`fsin_o`), qualified by the NCO's `out_valid`. Rounds and saturates the product to the output width. Accumulates `R` consecutive mixed samples and emits one decimated sum per frame to the following filter stage (FIR/CIC).

## Interface
Parameters:
- `mpr`, 16, NCO sample width (signed two's complement).
- `dw`, 16, ADC sample width (signed).
- `ow`, 16, mixer output width.
- `rw`, 8, width of the decimation-ratio input; the accumulator is `ow+rw` bits.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `clken`  in  1  global clock enable; all state holds while low.
- `adc_i`  in  `dw`  ADC sample, signed.
- `nco_sin_i`  in  `mpr`  NCO sine sample (NCO `fsin_o`), signed.
- `nco_valid_i`  in  1  NCO `out_valid`; qualifies `adc_i`/`nco_sin_i`.
- `dec_r_i`  in  `rw`  decimation ratio R; 0 is treated as 1.
- `mix_o`  out  `ow`  rounded/saturated mixer product.
- `mix_valid_o`  out  1  `mix_o` is valid this cycle.
- `acc_o`  out  `ow+rw`  decimated sum, signed.
- `acc_valid_o`  out  1  `acc_o` is valid this cycle.

## Operation
- A sample is accepted when `clken=1` and `nco_valid_i=1`.
- All pipeline registers advance only when `clken=1`. When `clken=0`, every register and output holds, including the valid flags.
- **S1:** register `adc_i` and `nco_sin_i`. `v1 <= nco_valid_i`.
- **S2:** full signed product `p = a*s`, `dw+mpr` bits. `v2 <= v1`.
- **S3 (round/saturate):** `q = (p + 2^(mpr-2)) >>> (mpr-1)`, taking the `ow` LSBs. If `q` exceeds `+2^(ow-1)-1`, clamp to `2^(ow-1)-1`; for defaults this happens only for (-32768)*(-32768). Negative overflow is impossible for defaults; a saturate-low path is still required for general parameters. Result goes to `mix_o`; `mix_valid_o <= v2`.
- **Decimator:** counter `cnt` runs 0..R-1. Accumulator `acc` is `ow+rw` bits, sign-extended add.
  - R is latched into `r_q` from `dec_r_i`, with 0 mapped to 1, whenever a mixed sample arrives with `cnt==0`. That same sample uses the live value. Changing `dec_r_i` mid-frame has no effect until the next frame.
  - On each `mix_valid_o` (with `clken`): if `cnt == R_eff-1`, then `acc_o <= acc + mix_o`, `acc_valid_o <= 1`, `acc <= 0`, `cnt <= 0`. Otherwise `acc <= acc + mix_o`, `cnt <= cnt+1`, `acc_valid_o <= 0`.
  - With no `mix_valid_o` and `clken=1`: `acc_valid_o <= 0`, and accumulator/counter hold.
- The accumulator cannot overflow: `ow+rw` bits hold 255 full-scale samples.
- **Reset:** `mix_o`, `mix_valid_o`, `acc_o`, `acc_valid_o`, all pipeline registers, `acc`, and `cnt` go to 0; `r_q` goes to 1. Reset overrides `clken`. Reset mid-frame discards the partial sum; no output is emitted.

## Timing
- Mixer latency: 3 enabled cycles from accept to `mix_valid_o`.
- Decimated output: `acc_valid_o` rises 1 enabled cycle after the R-th `mix_valid_o` of a frame, i.e. 4 enabled cycles after the R-th accepted sample.
- `acc_valid_o` is a one-enabled-cycle pulse per frame.
- Throughput: one sample per cycle; no backpressure.
- Gaps in `nco_valid_i` propagate as gaps in `mix_valid_o` and do not advance `cnt`.

## Structure
- Shared package `ddc_pkg`:
  - default widths `mpr`, `dw`, `ow`, `rw`;
  - round constant `2^(mpr-2)`;
  - saturation limits `2^(ow-1)-1` and `-2^(ow-1)`.
- Sub-module `ddc_round_sat` (combinational): `dw+mpr`-bit signed product in, `ow` bits out, rounding plus saturation. Reused by downstream FIR output stages.
- Top level contains the pipeline registers, decimation counter, and accumulator.

## Test plan
- **Reset / idle:** assert `reset` 3 cycles with `clken=1`, inputs nonzero -> all outputs 0; `acc_valid_o` stays 0 with `nco_valid_i=0`.
- **R=1 passthrough:** `dec_r_i=1`, `adc_i=16384`, `nco_sin_i=16384` constant -> `mix_o=8192`, `acc_o=8192` with `acc_valid_o=1` every cycle, first pulse 4 cycles after the first accept.
- **Saturation / rounding:**
  - `adc_i=-32768`, `nco_sin_i=-32768` -> `mix_o=32767`.
  - `adc_i=1`, `nco_sin_i=16384` -> `mix_o=1` (0.5 rounds up).
  - `adc_i=-1`, `nco_sin_i=16384` -> `mix_o=0`.
- **R=4 accumulation:** `dec_r_i=4`, `mix_o` sequence 100, -50, 200, 7 -> single `acc_o=257` pulse; next frame restarts from 0.
- **Stall and gaps:** toggle `clken` and `nco_valid_i` pseudo-randomly, R=3 -> `acc_o` matches a reference sum of every 3 valid samples; outputs hold while `clken=0`.
- **Reset mid-frame / R change:**
  - R=4, reset after 2 samples -> no pulse; the next 4 samples produce a correct sum.
  - Change `dec_r_i` from 4 to 2 mid-frame -> current frame still 4 samples, next frame 2.
  - `dec_r_i=0` -> behaves as R=1.
